// File: rtl/sram_resp_pkg.sv
//------------------------------------------------------------------------------
// Module  : sram_resp_pkg
// Brief   : Shared types and byte-merge helper for the sram_responder block.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_resp_pkg;

   localparam int WORD_BYTES = 4;
   localparam int IDX_W      = 30;

   typedef struct packed {
      logic [IDX_W-1:0]      index;
      logic [31:0]           data;
      logic [WORD_BYTES-1:0] mask;
   } wb_entry_t;

   function automatic logic [31:0] byte_merge(
      input logic [31:0]           old_w,
      input logic [31:0]           new_w,
      input logic [WORD_BYTES-1:0] mask
   );
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_responder_if.sv
//------------------------------------------------------------------------------
// Module  : sram_if
// Brief   : Memory-stage data bus: same-cycle read port plus byte-masked write.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_if;
   import sram_resp_pkg::*;

   logic                  sram_rd_en;
   logic [31:0]           sram_rd_addr;
   logic [31:0]           sram_rd_data;
   logic                  sram_wr_en;
   logic [31:0]           sram_wr_addr;
   logic [31:0]           sram_wr_data;
   logic [WORD_BYTES-1:0] sram_wr_mask;

   modport m (
      output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
      input  sram_rd_data
   );

   modport s (
      input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
      output sram_rd_data
   );
endinterface

`default_nettype wire

// File: rtl/sram_wb_fifo.sv
//------------------------------------------------------------------------------
// Module  : sram_wb_fifo
// Brief   : In-order write buffer with an age-ordered view (slot 0 = oldest).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_wb_fifo
   import sram_resp_pkg::*;
#(
   parameter int WB_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  wb_entry_t                  push_entry_i,
   input  logic                       pop_i,
   output wb_entry_t                  head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output wb_entry_t [WB_DEPTH-1:0]   view_o,
   output logic      [WB_DEPTH-1:0]   view_valid_o
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = $clog2(WB_DEPTH + 1);

   wb_entry_t        entries_q [WB_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             w_push, w_pop;

   assign full_o  = (count_q == CNT_W'(WB_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = entries_q[rd_ptr_q];

   // A push into a full buffer is legal only when the head leaves on the same edge.
   assign w_push = push_i && (!full_o || pop_i);
   assign w_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) entries_q[wr_ptr_q] <= push_entry_i;
   end

   for (genvar k = 0; k < WB_DEPTH; k++) begin : g_view
      logic [PTR_W-1:0] w_slot;
      assign w_slot          = rd_ptr_q + PTR_W'(k);
      assign view_o[k]       = entries_q[w_slot];
      assign view_valid_o[k] = (CNT_W'(k) < count_q);
   end

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
//------------------------------------------------------------------------------
// Module  : sram_responder
// Brief   : Word-array data memory with same-cycle reads and byte-masked writes.
//           Macro SRAM_RESP_WRITE_BUFFER_EN selects the buffered single-port
//           variant; otherwise the array is written directly (1R1W).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int          DEPTH_WORDS = 16384,
   parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
   parameter int          WB_DEPTH    = 2
) (
   input  logic clk,
   input  logic rst,
   sram_if.s    sram_io,
   output logic mem_busy,
   output logic err_overflow,
   output logic err_range
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [31:0]      w_rd_off, w_wr_off;
   logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
   logic             w_rd_ok, w_wr_ok;
   logic [31:0]      w_rd_arr, w_rd_fwd;
   logic             err_range_q, err_range_d;
   logic             unused_bits;

   assign w_rd_off = sram_io.sram_rd_addr - BASE_ADDR;
   assign w_wr_off = sram_io.sram_wr_addr - BASE_ADDR;
   assign w_rd_idx = w_rd_off[31:2];
   assign w_wr_idx = w_wr_off[31:2];
   assign w_rd_ok  = (sram_io.sram_rd_addr >= BASE_ADDR) && ({2'b00, w_rd_idx} < 32'(DEPTH_WORDS));
   assign w_wr_ok  = (sram_io.sram_wr_addr >= BASE_ADDR) && ({2'b00, w_wr_idx} < 32'(DEPTH_WORDS));
   assign unused_bits = ^{w_rd_off[1:0], w_wr_off[1:0]};

   assign w_rd_arr             = mem_q[w_rd_idx[AW-1:0]];
   assign sram_io.sram_rd_data = w_rd_ok ? w_rd_fwd : 32'h0;

   assign err_range_d = err_range_q
                      | (sram_io.sram_rd_en && !w_rd_ok)
                      | (sram_io.sram_wr_en && !w_wr_ok);
   assign err_range   = err_range_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_range_q <= 1'b0;
      else     err_range_q <= err_range_d;
   end

`ifdef SRAM_RESP_WRITE_BUFFER_EN
   wb_entry_t                w_head, w_push_entry;
   wb_entry_t [WB_DEPTH-1:0] w_view;
   logic      [WB_DEPTH-1:0] w_view_valid;
   logic                     w_full, w_empty, w_push, w_pop, w_drop;
   logic                     err_ovf_q, err_ovf_d;
   logic                     unused_head;

   // The array port belongs to the read whenever one is present.
   assign w_pop  = !sram_io.sram_rd_en && !w_empty;
   assign w_drop = sram_io.sram_wr_en && w_wr_ok && w_full && sram_io.sram_rd_en;
   assign w_push = sram_io.sram_wr_en && w_wr_ok && !w_drop;

   assign w_push_entry = '{index: w_wr_idx, data: sram_io.sram_wr_data, mask: sram_io.sram_wr_mask};
   assign unused_head  = ^w_head.index[IDX_W-1:AW];

   sram_wb_fifo #(
      .WB_DEPTH (WB_DEPTH)
   ) u_wb_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (w_push),
      .push_entry_i (w_push_entry),
      .pop_i        (w_pop),
      .head_o       (w_head),
      .full_o       (w_full),
      .empty_o      (w_empty),
      .view_o       (w_view),
      .view_valid_o (w_view_valid)
   );

   always_comb begin
      w_rd_fwd = w_rd_arr;
      for (int k = 0; k < WB_DEPTH; k++) begin
         if (w_view_valid[k] && (w_view[k].index == w_rd_idx))
            w_rd_fwd = byte_merge(w_rd_fwd, w_view[k].data, w_view[k].mask);
      end
   end

   always_ff @(posedge clk) begin
      if (w_pop)
         mem_q[w_head.index[AW-1:0]] <= byte_merge(mem_q[w_head.index[AW-1:0]], w_head.data, w_head.mask);
   end

   assign err_ovf_d = err_ovf_q | w_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_ovf_q <= 1'b0;
      else     err_ovf_q <= err_ovf_d;
   end

   assign mem_busy     = w_full;
   assign err_overflow = err_ovf_q;
`else
   localparam int unused_wb_depth = WB_DEPTH;

   assign w_rd_fwd = w_rd_arr;

   always_ff @(posedge clk) begin
      if (sram_io.sram_wr_en && w_wr_ok)
         mem_q[w_wr_idx[AW-1:0]] <= byte_merge(mem_q[w_wr_idx[AW-1:0]],
                                               sram_io.sram_wr_data, sram_io.sram_wr_mask);
   end

   assign mem_busy     = 1'b0;
   assign err_overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/sram_responder.md
# sram_responder

Data-memory responder for the `sram_if` bus: it serves word-aligned, byte-masked reads and writes issued by the memory-access stage. Writes are absorbed into a small in-order write buffer and drained into a single-port word array during cycles with no read. Reads return same-cycle, with buffered bytes forwarded. It sits between the core's memory stage (`sram_if.m` side) and the simulated or on-chip data memory.

## Interface
- `DEPTH_WORDS`, 16384: array size in 32-bit words (64 KiB).
- `BASE_ADDR`, 32'h1C00_0000: byte address of word 0.
- `WB_DEPTH`, 2: write-buffer entries, power of two, at least 2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sram_io.sram_rd_en`  input  1  read request, this cycle.
- `sram_io.sram_rd_addr`  input  32  word-aligned byte address (bits [1:0] ignored).
- `sram_io.sram_rd_data`  output  32  read word, combinational, same cycle.
- `sram_io.sram_wr_en`  input  1  write request, this cycle.
- `sram_io.sram_wr_addr`  input  32  word-aligned byte address.
- `sram_io.sram_wr_data`  input  32  write data, already lane-shifted.
- `sram_io.sram_wr_mask`  input  4  byte enables; bit i selects bits [8i+7:8i].
- `mem_busy`  output  1  write buffer full; upstream must not issue a write while a read is also pending.
- `err_overflow`  output  1  sticky: a write was dropped.
- `err_range`  output  1  sticky: an access fell outside the array.

## Operation
- Word index = (addr − BASE_ADDR) >> 2. Out of range is addr < BASE_ADDR or index ≥ DEPTH_WORDS.
- Out-of-range read returns 32'h0. Out-of-range write is discarded and never enqueued. Both set `err_range`.
- Write buffer is a FIFO of {index, data, mask}. An accepted write enqueues at the end of its cycle.
- Drain: in any cycle with `sram_rd_en` = 0 and buffer non-empty, the oldest entry merges into the array under its mask at the edge.
- Read data = array word, overlaid with the masked bytes of every valid entry whose index matches, applied oldest to newest. The newest byte wins.
- A write in the same cycle as a read is not visible to that read. The read sees pre-write data.
- Full buffer handling:
  - Full, `sram_wr_en`, and `sram_rd_en` = 0: drain and enqueue happen on the same edge; the write is accepted.
  - Full, `sram_wr_en`, and `sram_rd_en` = 1: the write is dropped and `err_overflow` is set.
- Mask 4'b0000 with `sram_wr_en` = 1 is accepted and enqueued; it has no effect on data.
- Array contents are not reset. Reset clears buffer pointers, count, and the error flags. Buffered writes pending at reset are lost.

## Timing
- Reset values: `mem_busy` = 0, `err_overflow` = 0, `err_range` = 0, buffer empty.
- `sram_rd_data` is valid in the same cycle as `sram_rd_en` (zero latency).
- Write accepted in cycle N: forwarded to reads from cycle N+1, committed to the array at the end of the first non-read cycle once it is oldest.
- `mem_busy` = (count == WB_DEPTH), decoded from registered count. It rises the cycle after the filling write.
- Count per edge: +1 on enqueue, −1 on drain, unchanged when both or neither occur. Pointers wrap modulo WB_DEPTH.
- Error flags set at the edge ending the offending cycle and hold until `rst`.

## Configuration
- `SRAM_RESP_WRITE_BUFFER_EN` defined: buffered single-port behaviour as above.
- Not defined: the array is modelled 1R1W; writes commit directly at the edge; no forwarding structure; `mem_busy` and `err_overflow` are tied 0. `err_range` and same-cycle read-before-write semantics are unchanged.

## Structure
- Package `sram_resp_pkg`: `wb_entry_t` struct {index, data[31:0], mask[3:0]}, `WORD_BYTES` = 4, and a byte-merge function (old, new, mask).
- Sub-module `sram_wb_fifo`: entries, pointers, count, full/empty, and a flattened entry view for forwarding. Instantiated only under the macro.

## Test plan
- Reset, then read 32'h1C00_0000 -> flags 0, `mem_busy` 0.
- Write 32'hAABBCCDD mask 4'hF at 32'h1C00_0010 in cycle N, then read it in cycle N+1 with `rd_en` held high (so it is forwarded, not drained) -> 32'hAABBCCDD.
- Write 32'h0000_5500 mask 4'b0010 to a word holding 32'h11223344, read next cycle -> 32'h11225544. Idle, then read again -> same value from the array.
- Two writes while reads are continuous -> `mem_busy` = 1. A third write with `rd_en` = 1 -> dropped, `err_overflow` = 1. A write with `rd_en` = 0 while full -> accepted, count stays 2.
- Read 32'h1BFF_FFFC -> 0 and `err_range` = 1. Write to index DEPTH_WORDS -> discarded, array unchanged.
- Assert `rst` mid-drain with 2 entries pending -> `mem_busy` = 0 immediately (async) and the pending data is never committed.
